// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus-cycle engine and the sequencers that drive it:
// state encoding, default phase timings and read/write encodings.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_GAP,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_DONE
    } bus_state_t;

    localparam int T_SETUP_DEFAULT  = 2;
    localparam int T_STROBE_DEFAULT = 10;
    localparam int T_HOLD_DEFAULT   = 2;
    localparam int T_GAP_DEFAULT    = 6;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rtc_bus_cycle_if.sv
// Request handshake plus RTC pin-side signals of the bus-cycle engine.
// slave is the engine; master is the sequencer together with the pin-level AD buffer.
interface rtc_bus_cycle_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ChipSelect;
    logic       Read;
    logic       Write;
    logic       AoD;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport master (
        output start, rw, addr, wdata, ad_in,
        input  busy, done, rdata, ChipSelect, Read, Write, AoD, ad_out, ad_oe
    );

    modport slave (
        input  start, rw, addr, wdata, ad_in,
        output busy, done, rdata, ChipSelect, Read, Write, AoD, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_phase_timer.sv
// 8-bit loadable down-counter that times each bus-cycle phase; zero marks the
// last cycle of the current phase.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       zero
);
    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != 8'd0) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign zero = (count_reg == 8'd0);
endmodule

// File: rtl/rtc_bus_cycle.sv
// Two-phase RTC bus-cycle engine: address phase (AoD=0) then data phase (AoD=1),
// with every pin output registered from the next state so strobes are glitch-free.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP  = T_SETUP_DEFAULT,
    parameter int T_STROBE = T_STROBE_DEFAULT,
    parameter int T_HOLD   = T_HOLD_DEFAULT,
    parameter int T_GAP    = T_GAP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    rtc_bus_cycle_if.slave  bus
);
    bus_state_t state_reg, state_next;
    logic       phase_zero;
    logic       accept;
    logic       rw_reg, rw_sel;
    logic [7:0] addr_reg, addr_sel;
    logic [7:0] wdata_reg, wdata_sel;
    logic       cs_reg, rd_reg, wr_reg, aod_reg, oe_reg, busy_reg, done_reg;
    logic       cs_next, rd_next, wr_next, aod_next, oe_next, busy_next, done_next;
    logic [7:0] ad_reg, ad_next, rdata_reg;

    function automatic logic [7:0] phase_length(input bus_state_t st);
        case (st)
            ST_A_SETUP, ST_D_SETUP:   return 8'(T_SETUP - 1);
            ST_A_STROBE, ST_D_STROBE: return 8'(T_STROBE - 1);
            ST_A_HOLD, ST_D_HOLD:     return 8'(T_HOLD - 1);
            ST_GAP:                   return 8'(T_GAP - 1);
            default:                  return 8'd0;
        endcase
    endfunction

    // Reloading on every state change gives each timed state exactly its count of cycles.
    rtc_phase_timer u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (state_next != state_reg),
        .load_value (phase_length(state_next)),
        .zero       (phase_zero)
    );

    assign accept    = (state_reg == ST_IDLE) && bus.start;
    assign rw_sel    = accept ? bus.rw    : rw_reg;
    assign addr_sel  = accept ? bus.addr  : addr_reg;
    assign wdata_sel = accept ? bus.wdata : wdata_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            rw_reg    <= RW_WRITE;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            rw_reg    <= rw_sel;
            addr_reg  <= addr_sel;
            wdata_reg <= wdata_sel;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (bus.start) state_next = ST_A_SETUP;
            ST_A_SETUP:  if (phase_zero) state_next = ST_A_STROBE;
            ST_A_STROBE: if (phase_zero) state_next = ST_A_HOLD;
            ST_A_HOLD:   if (phase_zero) state_next = ST_GAP;
            ST_GAP:      if (phase_zero) state_next = ST_D_SETUP;
            ST_D_SETUP:  if (phase_zero) state_next = ST_D_STROBE;
            ST_D_STROBE: if (phase_zero) state_next = ST_D_HOLD;
            ST_D_HOLD:   if (phase_zero) state_next = ST_DONE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they change on the same edge.
    always_comb begin
        cs_next   = 1'b1;
        rd_next   = 1'b1;
        wr_next   = 1'b1;
        aod_next  = 1'b0;
        oe_next   = 1'b0;
        ad_next   = '0;
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
        case (state_next)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                cs_next = 1'b0;
                oe_next = 1'b1;
                ad_next = addr_sel;
                wr_next = (state_next != ST_A_STROBE);
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                cs_next  = 1'b0;
                aod_next = 1'b1;
                if (rw_sel == RW_READ) begin
                    rd_next = (state_next != ST_D_STROBE);
                end else begin
                    oe_next = 1'b1;
                    ad_next = wdata_sel;
                    wr_next = (state_next != ST_D_STROBE);
                end
            end
            ST_GAP, ST_DONE: aod_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_reg    <= 1'b1;
            rd_reg    <= 1'b1;
            wr_reg    <= 1'b1;
            aod_reg   <= 1'b0;
            oe_reg    <= 1'b0;
            ad_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            rdata_reg <= '0;
        end else begin
            cs_reg    <= cs_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            aod_reg   <= aod_next;
            oe_reg    <= oe_next;
            ad_reg    <= ad_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            if (state_reg == ST_D_STROBE && phase_zero && rw_reg == RW_READ) begin
                rdata_reg <= bus.ad_in;
            end
        end
    end

    assign bus.ChipSelect = cs_reg;
    assign bus.Read       = rd_reg;
    assign bus.Write      = wr_reg;
    assign bus.AoD        = aod_reg;
    assign bus.ad_oe      = oe_reg;
    assign bus.ad_out     = ad_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.rdata      = rdata_reg;
endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Bench for rtc_bus_cycle: directed transactions feed expected done/strobe queues,
// independent monitors pop and compare; a second instance covers minimum timings.
`timescale 1ns/1ps
module tb_rtc_bus_cycle;
    import rtc_bus_pkg::*;

    typedef struct {
        int         done_cyc;
        logic       is_read;
        logic [7:0] rdata;
    } txn_t;

    typedef struct {
        logic       aod;
        logic       is_read;
        logic       oe;
        logic [7:0] ad;
        int         width;
    } strobe_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    logic [7:0] rd_val = 8'h00;

    txn_t    txn_q[$];
    strobe_t strobe_q[$];
    int      last_done = -10;

    rtc_bus_cycle_if bus ();
    rtc_bus_cycle_if fbus ();

    assign bus.ad_in  = bus.Read ? 8'h00 : rd_val;
    assign fbus.ad_in = 8'h00;

    rtc_bus_cycle u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    rtc_bus_cycle #(
        .T_SETUP  (1),
        .T_STROBE (1),
        .T_HOLD   (1),
        .T_GAP    (1)
    ) u_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (fbus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a request for one cycle; k is the edge that accepted it. Done lands
    // at spec cycle k+35, i.e. cyc == k+34 when sampled on the falling edge.
    task automatic issue(input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rv, output int k);
        txn_t    t;
        strobe_t s;
        bus.start = 1'b1;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = d;
        rd_val    = rv;
        @(negedge clk);
        bus.start = 1'b0;
        k = cyc;
        t.done_cyc = k + 34;
        t.is_read  = r;
        t.rdata    = rv;
        txn_q.push_back(t);
        s.aod = 1'b0; s.is_read = 1'b0; s.oe = 1'b1; s.ad = a; s.width = 10;
        strobe_q.push_back(s);
        s.aod = 1'b1; s.is_read = r; s.oe = !r; s.ad = r ? 8'h00 : d; s.width = 10;
        strobe_q.push_back(s);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((bus.busy || txn_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
            txn_q.delete();
            strobe_q.delete();
        end
    endtask

    // Done / busy monitor.
    initial begin
        txn_t t;
        logic busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && bus.done) begin
                if (txn_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
                end else begin
                    t = txn_q.pop_front();
                    check("done_cycle", cyc, t.done_cyc);
                    check("busy_in_done", bus.busy, 1'b1);
                    if (t.is_read) check("rdata", bus.rdata, t.rdata);
                end
                last_done = cyc;
            end
            if (reset && busy_prev && !bus.busy) check("busy_fall", cyc, last_done + 1);
            busy_prev = reset && bus.busy;
        end
    end

    // Strobe monitor: width, phase, drive and setup/hold stability of each strobe.
    initial begin
        strobe_t run, e;
        logic    run_act = 1'b0;
        logic    stable = 1'b1;
        logic    lw, lr;
        logic [8:0] cur, hist1 = '0, hist2 = '0, held = '0;
        int      hold_left = 0;
        forever begin
            @(negedge clk);
            cur = {bus.ad_oe, bus.ad_out};
            if (!reset) begin
                run_act = 1'b0;
                hold_left = 0;
            end else begin
                lw = !bus.Write;
                lr = !bus.Read;
                check("rd_wr_exclusive", {31'd0, lw & lr}, 0);
                check("strobe_without_cs", {31'd0, (lw | lr) & bus.ChipSelect}, 0);
                if (hold_left > 0) begin
                    check("hold_ad", cur, held);
                    hold_left--;
                end
                if (run_act) begin
                    if (run.is_read ? lr : lw) begin
                        run.width++;
                        if (bus.AoD !== run.aod || cur !== {run.oe, run.ad}) stable = 1'b0;
                    end else begin
                        run_act = 1'b0;
                        if (strobe_q.size() == 0) begin
                            checks++;
                            fails++;
                            $display("FAIL unexpected_strobe: ended cycle %0d aod=%0b ad=%0h, required none", cyc, run.aod, run.ad);
                        end else begin
                            e = strobe_q.pop_front();
                            check("strobe_kind", run.is_read, e.is_read);
                            check("strobe_aod", run.aod, e.aod);
                            check("strobe_oe", run.oe, e.oe);
                            check("strobe_width", run.width, e.width);
                            check("strobe_stable", stable, 1'b1);
                            if (!e.is_read) check("strobe_ad", run.ad, e.ad);
                        end
                        held = {run.oe, run.ad};
                        check("hold_ad", cur, held);
                        hold_left = 1;
                    end
                end else if (lw || lr) begin
                    run_act = 1'b1;
                    run.is_read = lr;
                    run.aod = bus.AoD;
                    run.oe = bus.ad_oe;
                    run.ad = bus.ad_out;
                    run.width = 1;
                    stable = 1'b1;
                    check("setup_ad", {hist2, hist1}, {cur, cur});
                end
            end
            hist2 = hist1;
            hist1 = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        int k, d, n;
        logic [4:0] fast_exp [9];
        // {ChipSelect, Write, AoD, done, ad_oe} per cycle after acceptance with all timings = 1
        fast_exp[0] = 5'b01001;  // A_SETUP
        fast_exp[1] = 5'b00001;  // A_STROBE
        fast_exp[2] = 5'b01001;  // A_HOLD
        fast_exp[3] = 5'b11100;  // GAP
        fast_exp[4] = 5'b01101;  // D_SETUP
        fast_exp[5] = 5'b00101;  // D_STROBE
        fast_exp[6] = 5'b01101;  // D_HOLD
        fast_exp[7] = 5'b11110;  // DONE
        fast_exp[8] = 5'b11000;  // IDLE

        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0;
        fbus.start = 1'b0; fbus.rw = 1'b0; fbus.addr = '0; fbus.wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_cs", bus.ChipSelect, 1'b1);
        check("rst_read", bus.Read, 1'b1);
        check("rst_write", bus.Write, 1'b1);
        check("rst_aod", bus.AoD, 1'b0);
        check("rst_oe", bus.ad_oe, 1'b0);
        check("rst_ad", bus.ad_out, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_rdata", bus.rdata, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Write with default timing.
        issue(RW_WRITE, 8'h21, 8'h45, 8'h00, k);
        check("busy_after_start", bus.busy, 1'b1);
        wait_idle("write");
        $display("txn write addr=21 wdata=45 accepted at %0d", k);

        // Read with default timing, RTC returns 59.
        @(negedge clk);
        issue(RW_READ, 8'h22, 8'h00, 8'h59, k);
        wait_idle("read");
        repeat (3) @(negedge clk);
        check("rdata_hold", bus.rdata, 8'h59);
        $display("txn read addr=22 accepted at %0d", k);

        // A start while busy must be ignored.
        @(negedge clk);
        issue(RW_WRITE, 8'h31, 8'h4a, 8'h00, k);
        while (cyc < k + 9) @(negedge clk);
        bus.start = 1'b1; bus.rw = RW_READ; bus.addr = 8'h77; bus.wdata = 8'h88;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("busy_start");
        $display("txn write addr=31 with ignored start, accepted at %0d", k);

        // Back-to-back: start in the cycle right after done.
        @(negedge clk);
        issue(RW_WRITE, 8'h10, 8'ha5, 8'h00, k);
        n = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
        end
        d = cyc;
        check("b2b_first_done", bus.done, 1'b1);
        @(negedge clk);
        check("b2b_idle_busy", bus.busy, 1'b0);
        check("b2b_idle_cs", bus.ChipSelect, 1'b1);
        issue(RW_READ, 8'h11, 8'h00, 8'h3c, k);
        check("b2b_accept", k, d + 2);
        check("b2b_cs", bus.ChipSelect, 1'b0);
        wait_idle("b2b");
        $display("txn back-to-back read addr=11 accepted at %0d, first done at %0d", k, d);

        // Reset in the middle of the data strobe of a write.
        @(negedge clk);
        issue(RW_WRITE, 8'h33, 8'h66, 8'h00, k);
        while (cyc < k + 24) @(negedge clk);
        check("pre_reset_write", bus.Write, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_cs", bus.ChipSelect, 1'b1);
        check("mid_rst_write", bus.Write, 1'b1);
        check("mid_rst_read", bus.Read, 1'b1);
        check("mid_rst_oe", bus.ad_oe, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        txn_q.delete();
        strobe_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_idle", bus.busy, 1'b0);
        issue(RW_READ, 8'h24, 8'h00, 8'h9c, k);
        wait_idle("post_reset_read");
        $display("txn reset mid-write, then read addr=24 accepted at %0d", k);

        // Minimum timings on the second instance.
        @(negedge clk);
        fbus.start = 1'b1; fbus.rw = RW_WRITE; fbus.addr = 8'h5a; fbus.wdata = 8'hc3;
        @(negedge clk);
        fbus.start = 1'b0;
        k = cyc;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("fast_pins_%0d", i),
                  {fbus.ChipSelect, fbus.Write, fbus.AoD, fbus.done, fbus.ad_oe}, fast_exp[i]);
            check($sformatf("fast_read_%0d", i), fbus.Read, 1'b1);
            if (i == 1) check("fast_ad_addr", fbus.ad_out, 8'h5a);
            if (i == 5) check("fast_ad_data", fbus.ad_out, 8'hc3);
        end
        $display("txn fast write addr=5a wdata=c3 accepted at %0d", k);

        repeat (3) @(negedge clk);
        check("final_queue_empty", txn_q.size() + strobe_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Bus-cycle engine for the RTC's multiplexed 8-bit address/data port, directly downstream of the initialisation and read sequencers. It accepts one register transaction (address plus write data, or address plus read request) and executes the two-phase RTC bus cycle: an address phase with AoD low, then a data phase with AoD high. It produces registered, glitch-free ChipSelect/Read/Write/AoD strobes, drives or releases the AD bus, and returns captured read data. It replaces free-running strobe generation with a handshake-controlled, parameter-timed cycle.

## Interface
- T_SETUP, 2: cycles of bus setup before each strobe (1..255)
- T_STROBE, 10: cycles the RD/WR strobe is held low (1..255)
- T_HOLD, 2: cycles of hold after each strobe (1..255)
- T_GAP, 6: cycles with CS high between address and data phase (1..255)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous reset, active low
- start  in  1  request pulse; sampled only in IDLE
- rw  in  1  1 = read, 0 = write; sampled with start
- addr  in  8  RTC register address; sampled with start
- wdata  in  8  write data; sampled with start
- busy  out  1  high from the cycle after start is accepted until DONE ends
- done  out  1  one-cycle pulse at transaction end
- rdata  out  8  captured read data; holds until the next read
- ChipSelect  out  1  RTC CS, active low
- Read  out  1  RTC RD, active low
- Write  out  1  RTC WR, active low
- AoD  out  1  0 = address phase, 1 = data phase
- ad_out  out  8  value driven on the AD bus
- ad_oe  out  1  1 = the FPGA drives the AD bus
- ad_in  in  8  AD bus sampled value

## Operation
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE.
- IDLE: when start=1, latch rw, addr and wdata, then go to A_SETUP. In any other state, start is ignored and no request is queued.
- Timed states occupy exactly their parameter count of cycles, then advance in list order. DONE lasts 1 cycle, then returns to IDLE.
- ChipSelect is 0 in A_SETUP..A_HOLD and D_SETUP..D_HOLD, and 1 elsewhere.
- AoD is 0 in IDLE and in the A_* states, and 1 in GAP, the D_* states and DONE.
- Address phase: ad_oe=1, ad_out=addr, Write=0 during A_STROBE only.
- Data phase, write: ad_oe=1, ad_out=wdata, Write=0 during D_STROBE only.
- Data phase, read: ad_oe=0, Read=0 during D_STROBE only. rdata captures ad_in on the last D_STROBE cycle.
- Read and Write are never low at the same time. Neither is low while ChipSelect=1.
- In IDLE: ad_oe=0 and ad_out=0.

## Timing
- Reset values: ChipSelect=Read=Write=1, AoD=0, ad_oe=0, ad_out=0, busy=0, done=0, rdata=0, state=IDLE.
- All outputs come directly from flops and take effect asynchronously on reset. Reset mid-cycle releases the bus immediately and discards the transaction, with no done pulse.
- Start accepted at edge k: the first A_SETUP cycle begins at k+1. done is high in cycle k+1+2·(T_SETUP+T_STROBE+T_HOLD)+T_GAP. With defaults, done is high in cycle k+35.
- busy falls in the cycle after done. A start asserted in the cycle after done is accepted.
- Strobe edges relative to AD changes:
  - AD data is stable T_SETUP cycles before the strobe falls.
  - AD data is stable T_HOLD cycles after the strobe rises.
  - ad_oe changes only while ChipSelect=1 or in a SETUP state.
- The phase counter is 8 bits. It loads PARAM−1 on state entry and advances the state when it reaches 0.

## Structure
- Shared package rtc_bus_pkg holds:
  - the state enumeration;
  - the default timing constants (T_SETUP/T_STROBE/T_HOLD/T_GAP);
  - the RW_READ/RW_WRITE encodings, which are shared with the sequencers.
- One sub-module, rtc_phase_timer: an 8-bit loadable down-counter with a load value and a zero flag, instantiated once.
- The top level instantiates rtc_bus_cycle between the data/address mux and the RTC pins. The AD tri-state buffer sits at the pin level, controlled by ad_oe.

## Test plan
- Write, defaults: start, rw=0, addr=8'h21, wdata=8'h45.
  - Address phase: Write low for exactly 10 cycles with ad_out=21 and AoD=0.
  - Data phase: Write low for 10 cycles with ad_out=45 and AoD=1.
  - done high at k+35. Read stays 1 throughout.
- Read, defaults: rw=1, addr=8'h22, bench drives ad_in=8'h59 during D_STROBE.
  - ad_oe=0 in the data phase.
  - rdata=8'h59 from the DONE cycle onward.
- Start while busy: second start at k+10 is ignored, yielding one done at k+35 and only one address strobe.
- Back-to-back: start again in the cycle after done. The second transaction's A_SETUP begins 2 cycles after the first done.
- Reset at k+25, mid D_STROBE, write:
  - Same cycle: ChipSelect, Write, Read all 1; ad_oe=0; busy=0.
  - No done pulse follows.
  - After release, a new read completes normally.
- Parameters T_SETUP=1, T_STROBE=1, T_HOLD=1, T_GAP=1: done at k+8. Each strobe is 1 cycle wide, and the CS-high gap is exactly 1 cycle.
